// File: rtl/record_fifo.sv
`default_nettype none
// ==== record_fifo: word-in / record-out FIFO with abort, flush and registered record output (rev 1.0) ====
module record_fifo #(
  parameter int WordSize          = 8,
  parameter int RecordWords       = 16,
  parameter int Depth             = 8,
  parameter int AlmostFullRecords = Depth - 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [WordSize-1:0]             in_data,
  output logic                            in_ready,
  input  logic                            in_abort,
  input  logic                            flush,
  output logic                            out_valid,
  output logic [WordSize*RecordWords-1:0] out_data,
  input  logic                            out_ready,
  output logic [$clog2(Depth):0]          records,
  output logic                            almost_full,
  output logic                            overflow
);

  localparam int RecordSizeBits = WordSize * RecordWords;
  localparam int StorageSize    = Depth * RecordWords;
  localparam int IdxW           = $clog2(StorageSize);
  localparam int PtrW           = IdxW + 1;
  localparam int RecW           = $clog2(RecordWords);
  localparam int SlotW          = IdxW - RecW;
  localparam int CntW           = $clog2(Depth) + 1;
  localparam logic [CntW:0] AfThreshold = (CntW + 1)'(AlmostFullRecords);

  // Word pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0]           write_pos;
  logic [PtrW-1:0]           commit_pos;
  logic [PtrW-1:0]           read_pos;
  logic [WordSize-1:0]       mem [StorageSize];
  logic [PtrW-1:0]           fill;
  logic [PtrW-1:0]           committed;
  logic [SlotW-1:0]          rd_slot;
  logic [RecordSizeBits-1:0] rd_record;
  logic                      accept;
  logic                      last_word;
  logic                      load;

  assign fill        = write_pos - read_pos;
  assign committed   = commit_pos - read_pos;
  assign in_ready    = (fill != PtrW'(StorageSize));
  assign records     = committed[PtrW-1:RecW];
  assign almost_full = ({1'b0, records} >= AfThreshold);

  assign accept    = in_valid && in_ready && !in_abort && !flush;
  assign last_word = &write_pos[RecW-1:0];
  assign load      = (records != '0) && (!out_valid || out_ready) && !flush;

  // read_pos always sits on a record boundary, so a record is one storage slot.
  assign rd_slot = read_pos[IdxW-1:RecW];

  generate
    for (genvar w = 0; w < RecordWords; w++) begin : g_gather
      assign rd_record[w*WordSize +: WordSize] = mem[{rd_slot, RecW'(w)}];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[write_pos[IdxW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_pos  <= '0;
      commit_pos <= '0;
      read_pos   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      write_pos  <= '0;
      commit_pos <= '0;
      read_pos   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (in_abort) begin
        write_pos <= commit_pos;
      end else if (accept) begin
        write_pos <= write_pos + 1'b1;
        if (last_word) begin
          commit_pos <= write_pos + 1'b1;
        end
      end

      if (load) begin
        read_pos  <= read_pos + PtrW'(RecordWords);
        out_valid <= 1'b1;
        out_data  <= rd_record;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
